button_driver: RTL and testbench
================================

BUTTON_DRIVER -- requirements
Module: button_driver

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 100000, giving the consecutive cycles a synchronized input must hold a new level before it is accepted; legal range 1 to 2^CNT_WIDTH-1.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 20, giving the width of each per-bit debounce counter.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port rstrb, input, 1 bit: read strobe; accepted for bus uniformity; no side effects.
REQ-006 The block SHALL have port wstrb, input, 1 bit: write strobe.
REQ-007 The block SHALL have port sel, input, 1 bit: device select; reads and writes are ignored while low.
REQ-008 The block SHALL have port wdata, input, 32 bits: write data; bits [3:0] are write-1-to-clear for the pressed flags.
REQ-009 The block SHALL have port rdata, output, 32 bits: read data.
REQ-010 The block SHALL have port BUTTONS, input, 4 bits: asynchronous, active-high button pins.
REQ-011 The block SHALL have port irq, output, 1 bit: high while any pressed flag is set.

Function
REQ-012 Each BUTTONS bit SHALL pass through a two-flop synchronizer (sync1, then sync2); only sync2 feeds the debounce logic.
REQ-013 Each bit SHALL keep a stable state register and a CNT_WIDTH-bit counter cnt, updated every cycle as follows:
- sync2 == stable: cnt <= 0.
- otherwise, if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
- otherwise: cnt <= cnt + 1.
REQ-014 A pin level held constant SHALL appear in stable exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 SHALL leave stable unchanged, and its counter SHALL return to 0 on the first cycle sync2 again equals stable.
REQ-016 A pressed flag SHALL be set on the same edge its stable bit changes from 0 to 1.
- A 1-to-0 change of stable SHALL NOT affect the flag.
- The flag SHALL stay set until cleared.
REQ-017 When sel && wstrb, each pressed bit i with wdata[i]=1 SHALL clear on that edge; bits with wdata[i]=0 SHALL be unchanged, and wdata[31:4] SHALL be ignored.
REQ-018 If a set (REQ-016) and a clear (REQ-017) hit the same bit on the same edge, the set SHALL win and the bit SHALL read 1 afterwards.
REQ-019 rdata SHALL be combinational: {24'b0, pressed[3:0], stable[3:0]} when sel=1, and 32'b0 when sel=0.
REQ-020 irq SHALL be the registered-state OR of pressed[3:0], with no extra delay beyond the pressed registers.
REQ-021 Bits SHALL be fully independent; simultaneous activity on several bits SHALL produce the same per-bit results as activity on one bit alone.
REQ-022 Writes with sel=0, and any rstrb activity, SHALL change no state.

Reset
REQ-023 When reset=1 at a rising edge, sync1, sync2, stable, every cnt and pressed SHALL all become 0, so rdata reads 0 and irq reads 0 on the next cycle.
REQ-024 Reset SHALL take priority over debounce updates and writes on the same edge.
REQ-025 A debounce in progress when reset is asserted SHALL be discarded; after release, a still-held pin SHALL restart from cnt=0 and reach stable after DEBOUNCE_CYCLES+2 edges.
REQ-026 A pin held high through reset release SHALL set its pressed flag on reaching stable (REQ-025).

Verification (DEBOUNCE_CYCLES=4)
REQ-027 The bench SHALL cover a clean press:
- Stimulus: after reset, BUTTONS=4'b0001 held.
- Response: rdata=0x11 and irq=1 exactly 6 edges after the first sampling edge, with rdata=0x00 on every earlier cycle.
REQ-028 The bench SHALL cover glitch rejection:
- Stimulus: BUTTONS[2] high for 3 cycles, then low.
- Response: rdata stays 0x00 and irq stays 0 throughout.
REQ-029 The bench SHALL cover release and clear:
- Stimulus: with bit0 pressed and stable, release the pin, then 6 edges later write wdata=0x1 with sel=1 and wstrb=1.
- Response: rdata is 0x10 after the release and before the write, then 0x00 after the write; irq falls on the write edge.
REQ-030 The bench SHALL cover set/clear collision:
- Stimulus: a W1C write of bit3 lands on the edge bit3's stable goes 0 to 1.
- Response: pressed[3]=1 afterwards, and rdata=0x88.
REQ-031 The bench SHALL cover reset mid-debounce:
- Stimulus: BUTTONS=4'b1111 held; reset pulsed for 1 cycle 3 edges in.
- Response: rdata=0x00 immediately after reset, then 0xFF exactly 6 edges after reset release.
REQ-032 The bench SHALL cover select gating:
- Stimulus: a pressed bit is set; then sel=0 with wstrb=1 and wdata=0xF.
- Response: rdata=0 while sel=0; with sel=1 the pressed bits still read set.

Source files
------------

// File: rtl/button_driver_if.sv
// Register-bus bundle for the button driver: strobes, select and data paths.
interface button_driver_if;
  logic        rstrb;
  logic        wstrb;
  logic        sel;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rstrb, wstrb, sel, wdata, input rdata);
  modport slave  (input rstrb, wstrb, sel, wdata, output rdata);
endinterface

// File: rtl/button_driver.sv
// Four-button input block: 2-flop synchronizer, per-bit debounce counter,
// sticky write-1-to-clear pressed flags and a level interrupt.
module button_driver #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  button_driver_if.slave        bus,
  input  logic [3:0]            BUTTONS,
  output logic                  irq
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [3:0]           sync1_q, sync1_d;
  logic [3:0]           sync2_q, sync2_d;
  logic [3:0]           stable_q, stable_d;
  logic [3:0]           pressed_q, pressed_d;
  logic [CNT_WIDTH-1:0] cnt_q [4];
  logic [CNT_WIDTH-1:0] cnt_d [4];
  logic [3:0]           clr;
  logic [3:0]           rose;

  // rstrb and the upper write-data bits carry no meaning for this device
  logic unused_bus;
  assign unused_bus = ^{bus.rstrb, bus.wdata[31:4]};

  always_comb begin
    sync1_d  = BUTTONS;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
    // a rising edge of stable on the same clock as a clear wins
    clr       = (bus.sel && bus.wstrb) ? bus.wdata[3:0] : '0;
    rose      = stable_d & ~stable_q;
    pressed_d = (pressed_q & ~clr) | rose;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      pressed_q <= '0;
      cnt_q     <= '{default: '0};
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.rdata = bus.sel ? {24'b0, pressed_q, stable_q} : '0;
  assign irq       = |pressed_q;

endmodule

// File: tb/tb_button_driver.sv
// Bench for button_driver: directed cycle table for the corner cases, then
// randomized traffic checked against a behavioural model.
module tb_button_driver;

  localparam int D = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  buttons;
  logic        irq;
  logic        sel, wstrb, rstrb;
  logic [31:0] wdata;

  button_driver_if bus ();
  assign bus.sel   = sel;
  assign bus.wstrb = wstrb;
  assign bus.rstrb = rstrb;
  assign bus.wdata = wdata;

  button_driver #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(20)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .BUTTONS (buttons),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  btn;
    logic        s;
    logic        w;
    logic [31:0] wd;
    logic        rs;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } row_t;

  row_t vec[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model: pin delayed two samples; a level replaces the
  // accepted level after it has disagreed for D consecutive cycles.
  logic [3:0] m_s1, m_s2, m_stable, m_pressed;
  int         m_run [4];

  function automatic void model_edge();
    logic [3:0] old;
    logic [3:0] c;
    old = m_stable;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_pressed = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_stable[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == D) begin
          m_stable[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    c = (sel && wstrb) ? wdata[3:0] : 4'h0;
    m_pressed = (m_pressed & ~c) | (m_stable & ~old);
    m_s2 = m_s1;
    m_s1 = buttons;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(logic r, logic [3:0] b, logic s, logic w, logic [31:0] wd,
                              logic rs, logic [31:0] er, logic ei);
    row_t x;
    x.rst = r; x.btn = b; x.s = s; x.w = w; x.wd = wd; x.rs = rs;
    x.exp_rdata = er; x.exp_irq = ei;
    vec.push_back(x);
  endfunction

  initial begin
    reset = 1'b1; buttons = '0; sel = 1'b0; wstrb = 1'b0; rstrb = 1'b0; wdata = '0;
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_pressed = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;

    // clean press of bit0: visible on the sixth sampling edge
    add(1, 4'h0, 1, 0, 0, 0, 32'h00, 0);
    repeat (5) add(0, 4'h1, 1, 0, 0, 0, 32'h00, 0);
    add(0, 4'h1, 1, 0, 0, 0, 32'h11, 1);
    // release, then W1C of bit0
    repeat (5) add(0, 4'h0, 1, 0, 0, 0, 32'h11, 1);
    add(0, 4'h0, 1, 0, 0, 0, 32'h10, 1);
    add(0, 4'h0, 1, 1, 32'h1, 0, 32'h00, 0);
    // glitch on bit2 shorter than the debounce window
    repeat (3) add(0, 4'h4, 1, 0, 0, 0, 32'h00, 0);
    repeat (8) add(0, 4'h0, 1, 0, 0, 0, 32'h00, 0);
    // clear of bit3 on the same edge its stable level rises
    repeat (5) add(0, 4'h8, 1, 0, 0, 0, 32'h00, 0);
    add(0, 4'h8, 1, 1, 32'h8, 0, 32'h88, 1);
    repeat (5) add(0, 4'h0, 1, 0, 0, 0, 32'h88, 1);
    add(0, 4'h0, 1, 0, 0, 0, 32'h80, 1);
    add(0, 4'h0, 1, 1, 32'hFFFF_FFF8, 0, 32'h00, 0);
    // select gating: deselected write and read strobe leave state alone
    repeat (5) add(0, 4'h1, 1, 0, 0, 0, 32'h00, 0);
    add(0, 4'h1, 1, 0, 0, 0, 32'h11, 1);
    add(0, 4'h1, 0, 1, 32'hF, 1, 32'h00, 1);
    add(0, 4'h1, 0, 0, 0, 1, 32'h00, 1);
    add(0, 4'h1, 1, 0, 0, 1, 32'h11, 1);
    // reset pulse mid-debounce with all pins held
    add(1, 4'h0, 1, 0, 0, 0, 32'h00, 0);
    repeat (2) add(0, 4'hF, 1, 0, 0, 0, 32'h00, 0);
    add(1, 4'hF, 1, 0, 0, 0, 32'h00, 0);
    repeat (5) add(0, 4'hF, 1, 0, 0, 0, 32'h00, 0);
    add(0, 4'hF, 1, 0, 0, 0, 32'hFF, 1);

    foreach (vec[k]) begin
      reset = vec[k].rst; buttons = vec[k].btn; sel = vec[k].s;
      wstrb = vec[k].w;   wdata = vec[k].wd;    rstrb = vec[k].rs;
      step();
      check($sformatf("vec%0d_rdata", k), bus.rdata, vec[k].exp_rdata);
      check($sformatf("vec%0d_irq", k), {31'b0, irq}, {31'b0, vec[k].exp_irq});
    end

    // randomized traffic: pins change at random intervals (glitches and holds)
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 5) == 0) buttons = 4'($urandom);
      sel   = 1'($urandom);
      wstrb = ($urandom_range(0, 3) == 0);
      wdata = $urandom;
      rstrb = 1'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      step();
      check("rand_rdata", bus.rdata, sel ? {24'b0, m_pressed, m_stable} : 32'h0);
      check("rand_irq", {31'b0, irq}, {31'b0, |m_pressed});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
